fir_acc_dump: RTL and testbench

Integrate-and-dump stage placed directly downstream of the last cell of the FIR/correlator systolic chain. It consumes the chain's `adder_out` on every sample strobe and discards the pipeline-fill samples after a start. It sums a programmable number of valid lag outputs into a wide accumulator and hands each completed frame sum to the readout logic through a 2-entry buffered valid/ready interface.

---
 rtl/fir_corr_pkg.sv | 31 +++
 rtl/fir_acc_dump_if.sv | 12 +
 rtl/fir_acc_obuf.sv | 81 ++++++++
 rtl/fir_acc_dump.sv | 169 ++++++++++++++++
 tb/tb_fir_acc_dump.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_corr_pkg.sv
// Shared definitions for the FIR/correlator back end: default widths,
// the integrate-and-dump state encoding and the overflow classifier used
// by the saturating accumulator (built only when FIR_ACC_SAT_EN is defined).
package fir_corr_pkg;

    localparam int DEF_DIM_ADDER_IN = 32;
    localparam int DEF_DIM_ACC      = 48;
    localparam int DEF_DIM_LEN      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_INTEG = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_POS  = 2'd1,
        SAT_NEG  = 2'd2
    } sat_t;

    // Classifies a wrapped two's-complement sum from the operand and result
    // sign bits: like-signed operands with a result of the other sign overflowed.
    function automatic sat_t sat_kind(input logic a_msb, input logic b_msb,
                                      input logic sum_msb);
        if ((a_msb == b_msb) && (sum_msb != a_msb))
            return a_msb ? SAT_NEG : SAT_POS;
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/fir_acc_dump_if.sv
// Result bus from the integrate-and-dump stage to the readout logic:
// a registered frame sum with a valid/ready handshake.
interface fir_acc_dump_if #(
    parameter int DIM_ACC = fir_corr_pkg::DEF_DIM_ACC
);
    logic signed [DIM_ACC-1:0] acc_out;
    logic                      acc_valid;
    logic                      acc_ready;

    modport master (output acc_out, output acc_valid, input acc_ready);
    modport slave  (input acc_out, input acc_valid, output acc_ready);
endinterface

// File: rtl/fir_acc_obuf.sv
// Two-entry in-order result buffer. The head register drives the result bus
// directly so acc_out/acc_valid are registered and hold while stalled.
// A push that finds both slots occupied (and no pop that cycle) is dropped.
module fir_acc_obuf
    import fir_corr_pkg::*;
#(
    parameter int DIM_ACC = DEF_DIM_ACC
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic                      i_push,
    input  logic signed [DIM_ACC-1:0] i_data,
    output logic                      o_drop,
    fir_acc_dump_if.master            out_if
);

    logic signed [DIM_ACC-1:0] r_head;
    logic signed [DIM_ACC-1:0] r_tail;
    logic                      r_head_vld;
    logic                      r_tail_vld;

    logic signed [DIM_ACC-1:0] w_head_nxt;
    logic signed [DIM_ACC-1:0] w_tail_nxt;
    logic                      w_head_vld_nxt;
    logic                      w_tail_vld_nxt;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_accept;

    assign w_pop    = r_head_vld && out_if.acc_ready;
    assign w_full   = r_head_vld && r_tail_vld;
    // A pop in the same cycle frees a slot, so a push into a full buffer still lands.
    assign w_accept = i_push && (!w_full || w_pop);
    assign o_drop   = i_push && w_full && !w_pop;

    assign out_if.acc_out   = r_head;
    assign out_if.acc_valid = r_head_vld;

    // Next slot contents: shift the tail forward on pop, then append the push.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        w_head_nxt     = r_head;
        w_head_vld_nxt = r_head_vld;
        w_tail_nxt     = r_tail;
        w_tail_vld_nxt = r_tail_vld;
        if (w_pop) begin
            if (r_tail_vld)
                w_head_nxt = r_tail;
            w_head_vld_nxt = r_tail_vld;
            w_tail_vld_nxt = 1'b0;
        end
        if (w_accept) begin
            if (!w_head_vld_nxt) begin
                w_head_nxt     = i_data;
                w_head_vld_nxt = 1'b1;
            end else begin
                w_tail_nxt     = i_data;
                w_tail_vld_nxt = 1'b1;
            end
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            // NOTE: the data slots are reset too because acc_out must read 0 out of
            // reset; a deeper storage array would normally be left unreset.
            r_head     <= '0;
            r_tail     <= '0;
            r_head_vld <= 1'b0;
            r_tail_vld <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_head_vld <= w_head_vld_nxt;
            r_tail_vld <= w_tail_vld_nxt;
        end
    end

endmodule

// File: rtl/fir_acc_dump.sv
// Integrate-and-dump stage behind the last FIR/correlator chain cell.
// Discards FILL_CYCLES strobed samples after start, then sums int_len samples
// per frame and pushes each frame sum into a 2-entry result buffer.
// Optional build macro FIR_ACC_SAT_EN: saturating accumulator with sticky
// sat_flag; without it the accumulator wraps and sat_flag is tied low.
module fir_acc_dump
    import fir_corr_pkg::*;
#(
    parameter int DIM_ADDER_IN = DEF_DIM_ADDER_IN,
    parameter int DIM_ACC      = DEF_DIM_ACC,
    parameter int DIM_LEN      = DEF_DIM_LEN,
    parameter int FILL_CYCLES  = 2
) (
    input  logic                           clk,
    input  logic                           clr_n,
    input  logic                           start,
    input  logic                           stop,
    input  logic [DIM_LEN-1:0]             int_len,
    input  logic                           en,
    input  logic signed [DIM_ADDER_IN-1:0] adder_in,
    output logic                           busy,
    output logic                           overrun,
    output logic                           sat_flag,
    fir_acc_dump_if.master                 acc_if
);

    localparam int FILL_W = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [FILL_W-1:0]         r_fill_cnt;
    logic [DIM_LEN-1:0]        r_len;
    logic [DIM_LEN-1:0]        r_cnt;
    logic signed [DIM_ACC-1:0] r_acc;
    logic                      r_overrun;

    logic signed [DIM_ACC-1:0] w_addend;
    logic signed [DIM_ACC-1:0] w_wrap;
    logic signed [DIM_ACC-1:0] w_sum;
    logic                      w_fill_done;
    logic                      w_last;
    logic                      w_start_ok;
    logic                      w_abort;
    logic                      w_fill_en;
    logic                      w_integ_en;
    logic                      w_push;
    logic                      w_drop;

    assign w_addend    = DIM_ACC'(adder_in);
    assign w_wrap      = r_acc + w_addend;
    assign w_fill_done = (int'(r_fill_cnt) == FILL_CYCLES - 1);
    assign w_last      = (r_cnt == r_len - DIM_LEN'(1));

`ifdef FIR_ACC_SAT_EN
    sat_t w_kind;
    logic r_sat;

    assign w_kind = sat_kind(r_acc[DIM_ACC-1], w_addend[DIM_ACC-1], w_wrap[DIM_ACC-1]);

    // Clamp an overflowed sum to the signed extreme in the overflow direction.
    always_comb begin
        w_sum = w_wrap;
        case (w_kind)
            SAT_POS: w_sum = {1'b0, {(DIM_ACC-1){1'b1}}};
            SAT_NEG: w_sum = {1'b1, {(DIM_ACC-1){1'b0}}};
            default: w_sum = w_wrap;
        endcase
    end

    // Sticky saturation flag, cleared by an accepted start.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            r_sat <= 1'b0;
        else if (w_start_ok)
            r_sat <= 1'b0;
        else if (w_integ_en && (w_kind != SAT_NONE))
            r_sat <= 1'b1;
    end

    assign sat_flag = r_sat;
`else
    assign w_sum    = w_wrap;
    assign sat_flag = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; stop wins over a completing sample, start wins over stop in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = (FILL_CYCLES == 0) ? ST_INTEG : ST_FILL;
            ST_FILL:  if (stop) w_state_nxt = ST_IDLE;
                      else if (en && w_fill_done) w_state_nxt = ST_INTEG;
            ST_INTEG: if (stop) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded control strobes.
    always_comb begin
        busy       = (r_state != ST_IDLE);
        w_start_ok = (r_state == ST_IDLE) && start;
        w_abort    = (r_state != ST_IDLE) && stop;
        w_fill_en  = (r_state == ST_FILL) && en && !stop;
        w_integ_en = (r_state == ST_INTEG) && en && !stop;
        w_push     = w_integ_en && w_last;
    end

    // Accumulator, sample counter, fill counter and latched frame length.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_fill_cnt <= '0;
        end else if (w_start_ok) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_fill_cnt <= '0;
            r_len      <= (int_len == '0) ? DIM_LEN'(1) : int_len;
        end else if (w_abort) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else begin
            if (w_fill_en)
                r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            if (w_integ_en) begin
                if (w_last) begin
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + DIM_LEN'(1);
                end
            end
        end
    end

    // Sticky overrun flag, cleared by an accepted start.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            r_overrun <= 1'b0;
        else if (w_start_ok)
            r_overrun <= 1'b0;
        else if (w_drop)
            r_overrun <= 1'b1;
    end

    assign overrun = r_overrun;

    fir_acc_obuf #(
        .DIM_ACC (DIM_ACC)
    ) u_obuf (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_push (w_push),
        .i_data (w_sum),
        .o_drop (w_drop),
        .out_if (acc_if)
    );

endmodule

// File: tb/tb_fir_acc_dump.sv
// Self-checking bench for fir_acc_dump: a 48-bit instance checked through a
// result scoreboard and a 34-bit instance sharing its stimulus for the
// saturation/wrap case.
`timescale 1ns/1ps
module tb_fir_acc_dump;

    localparam logic signed [31:0] IDLE_IN = 32'sh5A5A5A5A;
`ifdef FIR_ACC_SAT_EN
    localparam logic signed [33:0] SAT_EXP  = 34'sd8589934591;
    localparam logic               SATF_EXP = 1'b1;
`else
    localparam logic signed [33:0] SAT_EXP  = -34'sd6442450949;
    localparam logic               SATF_EXP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               clr_n = 1'b0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               en = 1'b0;
    logic               ready = 1'b0;
    logic [15:0]        int_len = 16'd0;
    logic signed [31:0] adder_in = IDLE_IN;
    logic               busy, overrun, sat_flag;
    logic               busy_s, overrun_s, sat_flag_s;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pop   = 0;
    logic signed [47:0] sb[$];
    logic signed [47:0] mon_exp;

    fir_acc_dump_if #(.DIM_ACC(48)) acc_if();
    fir_acc_dump_if #(.DIM_ACC(34)) sat_if();
    assign acc_if.acc_ready = ready;
    assign sat_if.acc_ready = ready;

    fir_acc_dump #(.DIM_ADDER_IN(32), .DIM_ACC(48), .DIM_LEN(16), .FILL_CYCLES(2)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .int_len(int_len),
        .en(en), .adder_in(adder_in), .busy(busy), .overrun(overrun),
        .sat_flag(sat_flag), .acc_if(acc_if)
    );

    fir_acc_dump #(.DIM_ADDER_IN(32), .DIM_ACC(34), .DIM_LEN(16), .FILL_CYCLES(2)) dut_s (
        .clk(clk), .clr_n(clr_n), .start(start), .stop(stop), .int_len(int_len),
        .en(en), .adder_in(adder_in), .busy(busy_s), .overrun(overrun_s),
        .sat_flag(sat_flag_s), .acc_if(sat_if)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: a handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        if (clr_n && acc_if.acc_valid && ready) begin
            n_pop++;
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %0d, expected no result", acc_if.acc_out);
            end else begin
                mon_exp = sb.pop_front();
                if (acc_if.acc_out !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_result: got %0d, expected %0d", acc_if.acc_out, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic signed [31:0] v);
        en = 1'b1;
        adder_in = v;
        tick();
        en = 1'b0;
        adder_in = IDLE_IN;
    endtask

    task automatic do_start(input logic [15:0] len);
        int_len = len;
        start = 1'b1;
        tick();
        start = 1'b0;
        int_len = 16'd9;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 50) begin
            tick();
            k++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: got %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #3;
        n_tests++; if (acc_if.acc_out !== 48'sd0) begin n_fail++; $display("FAIL rst_acc_out: got %0d, expected 0", acc_if.acc_out); end
        n_tests++; if (acc_if.acc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", acc_if.acc_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b, expected 0", overrun); end
        n_tests++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL rst_sat: got %b, expected 0", sat_flag); end
        @(negedge clk);
        clr_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        ready = 1'b0;
        do_start(16'd4);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, expected 1", busy); end
        send(32'sd10); send(32'sd20);
        send(32'sd1); send(32'sd2); send(32'sd3);
        n_tests++; if (acc_if.acc_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b, expected 0", acc_if.acc_valid); end
        send(32'sd4);
        n_tests++; if (acc_if.acc_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b, expected 1", acc_if.acc_valid); end
        n_tests++; if (acc_if.acc_out !== 48'sd10) begin n_fail++; $display("FAIL basic_out: got %0d, expected 10", acc_if.acc_out); end
        tick(); tick();
        n_tests++; if (acc_if.acc_out !== 48'sd10 || acc_if.acc_valid !== 1'b1) begin n_fail++; $display("FAIL basic_hold: got %0d/%b, expected 10/1", acc_if.acc_out, acc_if.acc_valid); end
        sb.push_back(48'sd10);
        ready = 1'b1;
        wait_drain("basic");
        ready = 1'b0;
        do_stop();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got %b, expected 0", busy); end
    endtask

    task automatic test_sign();
        ready = 1'b1;
        do_start(16'd3);
        sb.push_back(48'shFFFF_FFFF_FFF1);
        sb.push_back(48'sd6);
        send(32'sd0); send(32'sd0);
        send(-32'sd5); send(-32'sd5); send(-32'sd5);
        send(32'sd1); send(32'sd2); send(32'sd3);
        wait_drain("sign");
        do_stop();
        ready = 1'b0;
    endtask

    task automatic test_backpressure();
        ready = 1'b0;
        do_start(16'd1);
        send(32'sd0); send(32'sd0);
        send(32'sd7); send(32'sd8);
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_no_overrun: got %b, expected 0", overrun); end
        send(32'sd9);
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_overrun: got %b, expected 1", overrun); end
        n_tests++; if (acc_if.acc_out !== 48'sd7) begin n_fail++; $display("FAIL bp_head: got %0d, expected 7", acc_if.acc_out); end
        do_stop();
        sb.push_back(48'sd7);
        sb.push_back(48'sd8);
        ready = 1'b1;
        wait_drain("bp");
        tick();
        n_tests++; if (acc_if.acc_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b, expected 0", acc_if.acc_valid); end
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL bp_sticky: got %b, expected 1", overrun); end
        ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        ready = 1'b0;
        do_start(16'd1);
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_clear: got %b, expected 0", overrun); end
        for (int i = 1; i <= 6; i++) sb.push_back(48'(i));
        send(32'sd0); send(32'sd0);
        send(32'sd1); send(32'sd2);
        ready = 1'b1;
        for (int i = 3; i <= 6; i++) send(32'(i));
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b, expected 0", overrun); end
        wait_drain("b2b");
        do_stop();
        ready = 1'b0;
    endtask

    task automatic test_sat();
        ready = 1'b0;
        do_start(16'd5);
        send(32'sd0); send(32'sd0);
        for (int i = 0; i < 5; i++) send(32'sh7FFFFFFF);
        n_tests++; if (acc_if.acc_out !== 48'sd10737418235) begin n_fail++; $display("FAIL sat_wide: got %0d, expected 10737418235", acc_if.acc_out); end
        n_tests++; if (sat_flag !== 1'b0) begin n_fail++; $display("FAIL sat_wide_flag: got %b, expected 0", sat_flag); end
        n_tests++; if (sat_if.acc_out !== SAT_EXP) begin n_fail++; $display("FAIL sat_narrow: got %0d, expected %0d", sat_if.acc_out, SAT_EXP); end
        n_tests++; if (sat_flag_s !== SATF_EXP) begin n_fail++; $display("FAIL sat_flag: got %b, expected %b", sat_flag_s, SATF_EXP); end
        sb.push_back(48'sd10737418235);
        ready = 1'b1;
        wait_drain("sat");
        do_stop();
        ready = 1'b0;
    endtask

    task automatic test_stop();
        ready = 1'b0;
        do_start(16'd4);
        send(32'sd0); send(32'sd0);
        send(32'sd1); send(32'sd2);
        do_stop();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %b, expected 0", busy); end
        send(32'sd50);
        tick(); tick();
        n_tests++; if (acc_if.acc_valid !== 1'b0) begin n_fail++; $display("FAIL stop_no_push: got %b, expected 0", acc_if.acc_valid); end
        do_start(16'd2);
        sb.push_back(48'sd11);
        send(32'sd0); send(32'sd0);
        send(32'sd5); send(32'sd6);
        ready = 1'b1;
        wait_drain("stop");
        do_stop();
        ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        ready = 1'b0;
        do_start(16'd2);
        send(32'sd0); send(32'sd0);
        send(32'sd9); send(32'sd9);
        send(32'sd1); send(32'sd1);
        send(32'sd3); send(32'sd3);
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL rmid_setup: got %b, expected 1", overrun); end
        send(32'sd4);
        #1;
        clr_n = 1'b0;
        #1;
        n_tests++; if (acc_if.acc_out !== 48'sd0) begin n_fail++; $display("FAIL rmid_out: got %0d, expected 0", acc_if.acc_out); end
        n_tests++; if (acc_if.acc_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b, expected 0", acc_if.acc_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b, expected 0", busy); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rmid_overrun: got %b, expected 0", overrun); end
        @(negedge clk);
        clr_n = 1'b1;
        tick(); tick();
        n_tests++; if (acc_if.acc_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_after: got %b/%b, expected 0/0", acc_if.acc_valid, busy); end
    endtask

    task automatic test_edge();
        int p0;
        ready = 1'b1;
        int_len = 16'd0;
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL edge_start_wins: got %b, expected 1", busy); end
        p0 = n_pop;
        sb.push_back(48'sd3);
        sb.push_back(48'sd4);
        sb.push_back(48'sd5);
        send(32'sd0); send(32'sd0);
        send(32'sd3); send(32'sd4);
        int_len = 16'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        send(32'sd5);
        wait_drain("edge");
        tick();
        n_tests++; if (n_pop - p0 !== 3) begin n_fail++; $display("FAIL edge_frames: got %0d, expected 3", n_pop - p0); end
        do_stop();
        ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sign();
        test_backpressure();
        test_back_to_back();
        test_sat();
        test_stop();
        test_reset_mid();
        test_edge();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
